// File: rtl/preamble_pkg.sv
// Shared definitions for the 802.11a TX preamble generator: lengths,
// FSM encoding and the Q1.15 short/long training symbol tables ({q,i} words).
package preamble_pkg;

   localparam int unsigned STS_LEN      = 16;
   localparam int unsigned LTS_LEN      = 64;
   localparam int unsigned PREAMBLE_LEN = 320;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_STS     = 3'd1,
      ST_LTS_GI  = 3'd2,
      ST_LTS     = 3'd3,
      ST_PAYLOAD = 3'd4
   } state_t;

   // Packs one complex sample into the {q,i} word layout used by the tables.
   function automatic logic [31:0] pack_iq(input logic signed [15:0] i,
                                          input logic signed [15:0] q);
      return {q, i};
   endfunction

   // Short training symbol, one 16-sample period.
   localparam logic [31:0] STS_ROM [STS_LEN] = '{
      pack_iq( 16'sd1507,  16'sd1507), pack_iq(-16'sd4325,  16'sd66),
      pack_iq(-16'sd426,  -16'sd2589), pack_iq( 16'sd4686, -16'sd426),
      pack_iq( 16'sd3015,  16'sd0),    pack_iq( 16'sd4686, -16'sd426),
      pack_iq(-16'sd426,  -16'sd2589), pack_iq(-16'sd4325,  16'sd66),
      pack_iq( 16'sd1507,  16'sd1507), pack_iq( 16'sd66,   -16'sd4325),
      pack_iq(-16'sd2589, -16'sd426),  pack_iq(-16'sd426,   16'sd4686),
      pack_iq( 16'sd0,     16'sd3015), pack_iq(-16'sd426,   16'sd4686),
      pack_iq(-16'sd2589, -16'sd426),  pack_iq( 16'sd66,   -16'sd4325)
   };

   // Long training symbol, one 64-sample period (the GI is its tail 32..63).
   localparam logic [31:0] LTS_ROM [LTS_LEN] = '{
      pack_iq( 16'sd5120,  16'sd0),    pack_iq(-16'sd164,  -16'sd3932),
      pack_iq( 16'sd1311, -16'sd3637), pack_iq( 16'sd3178,  16'sd2720),
      pack_iq( 16'sd688,   16'sd918),  pack_iq( 16'sd1966, -16'sd2884),
      pack_iq(-16'sd3768, -16'sd1802), pack_iq(-16'sd1245, -16'sd3473),
      pack_iq( 16'sd3211, -16'sd852),  pack_iq( 16'sd1737,  16'sd131),
      pack_iq( 16'sd33,   -16'sd3768), pack_iq(-16'sd4489, -16'sd1540),
      pack_iq( 16'sd786,  -16'sd1933), pack_iq( 16'sd1933, -16'sd492),
      pack_iq(-16'sd721,   16'sd5276), pack_iq( 16'sd3899, -16'sd131),
      pack_iq( 16'sd2032, -16'sd2032), pack_iq( 16'sd1212,  16'sd3211),
      pack_iq(-16'sd1868,  16'sd1278), pack_iq(-16'sd4293,  16'sd2130),
      pack_iq( 16'sd2687,  16'sd3015), pack_iq( 16'sd2294,  16'sd459),
      pack_iq(-16'sd1966,  16'sd2654), pack_iq(-16'sd1835, -16'sd721),
      pack_iq(-16'sd1147, -16'sd4948), pack_iq(-16'sd3998, -16'sd557),
      pack_iq(-16'sd4162, -16'sd688),  pack_iq( 16'sd2458, -16'sd2425),
      pack_iq(-16'sd98,    16'sd1769), pack_iq(-16'sd3015,  16'sd3768),
      pack_iq( 16'sd3015,  16'sd3473), pack_iq( 16'sd393,   16'sd3211),
      pack_iq(-16'sd5120,  16'sd0),    pack_iq( 16'sd393,  -16'sd3211),
      pack_iq( 16'sd3015, -16'sd3473), pack_iq(-16'sd3015, -16'sd3768),
      pack_iq(-16'sd98,   -16'sd1769), pack_iq( 16'sd2458,  16'sd2425),
      pack_iq(-16'sd4162,  16'sd688),  pack_iq(-16'sd3998,  16'sd557),
      pack_iq(-16'sd1147,  16'sd4948), pack_iq(-16'sd1835,  16'sd721),
      pack_iq(-16'sd1966, -16'sd2654), pack_iq( 16'sd2294, -16'sd459),
      pack_iq( 16'sd2687, -16'sd3015), pack_iq(-16'sd4293, -16'sd2130),
      pack_iq(-16'sd1868, -16'sd1278), pack_iq( 16'sd1212, -16'sd3211),
      pack_iq( 16'sd2032,  16'sd2032), pack_iq( 16'sd3899,  16'sd131),
      pack_iq(-16'sd721,  -16'sd5276), pack_iq( 16'sd1933,  16'sd492),
      pack_iq( 16'sd786,   16'sd1933), pack_iq(-16'sd4489,  16'sd1540),
      pack_iq( 16'sd33,    16'sd3768), pack_iq( 16'sd1737, -16'sd131),
      pack_iq( 16'sd3211,  16'sd852),  pack_iq(-16'sd1245,  16'sd3473),
      pack_iq(-16'sd3768,  16'sd1802), pack_iq( 16'sd1966,  16'sd2884),
      pack_iq( 16'sd688,  -16'sd918),  pack_iq( 16'sd3178, -16'sd2720),
      pack_iq( 16'sd1311,  16'sd3637), pack_iq(-16'sd164,   16'sd3932)
   };

endpackage

// File: rtl/preamble_rom.sv
// Registered STS/LTS table read. The same register also loads an external
// word (payload) so that it is the single output sample register.
module preamble_rom
   import preamble_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        rom_en,
   input  logic        sel_lts,
   input  logic [5:0]  idx,
   input  logic        ext_en,
   input  logic [31:0] ext_data,
   output logic [31:0] dout
);

   // Output word register: table read, external load, or zero when idle.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         dout <= 32'd0;
      end else if (rom_en) begin
         dout <= sel_lts ? LTS_ROM[idx] : STS_ROM[idx[3:0]];
      end else if (ext_en) begin
         dout <= ext_data;
      end else begin
         dout <= 32'd0;
      end
   end

endmodule

// File: rtl/lts_sts_preamble_gen.sv
// 802.11a TX preamble generator: 10 short symbols, LTS guard interval and two
// long symbols, then payload forwarding, one sample per DAC request strobe.
module lts_sts_preamble_gen
   import preamble_pkg::*;
#(
   parameter int unsigned STS_REPEAT = 10,
   parameter int unsigned LTS_GI_LEN = 32,
   parameter int unsigned LTS_REPEAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        tx_start,
   input  logic        sample_req,
   input  logic        payload_in_valid,
   input  logic [15:0] payload_in_i,
   input  logic [15:0] payload_in_q,
   input  logic        payload_in_last,
   output logic        payload_in_ready,
   output logic        sample_out_valid,
   output logic [15:0] sample_out_i,
   output logic [15:0] sample_out_q,
   output logic        preamble_done,
   output logic        tx_busy,
   output logic        underrun_err
);

   localparam logic [8:0] STS_LAST = 9'(STS_REPEAT * STS_LEN - 1);
   localparam logic [8:0] GI_LAST  = 9'(LTS_GI_LEN - 1);
   localparam logic [8:0] LTS_LAST = 9'(LTS_REPEAT * LTS_LEN - 1);
   localparam logic [5:0] GI_BASE  = 6'(LTS_LEN - LTS_GI_LEN);

   state_t      state_r, state_s;
   logic [8:0]  cnt_r, cnt_s;
   logic        valid_r, valid_s;
   logic        done_r, done_s;
   logic        underrun_r, underrun_s;
   logic        busy_r, busy_s;
   logic        ready_s;
   logic        rom_en_s, sel_lts_s, ext_en_s;
   logic [5:0]  rom_idx_s;
   logic [31:0] ext_data_s;
   logic [31:0] out_word_s;

   // Next-state, counter and sample-source selection for each request.
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      valid_s    = 1'b0;
      done_s     = 1'b0;
      underrun_s = 1'b0;
      busy_s     = busy_r;
      ready_s    = 1'b0;
      rom_en_s   = 1'b0;
      sel_lts_s  = 1'b0;
      rom_idx_s  = 6'd0;
      ext_en_s   = 1'b0;
      ext_data_s = 32'd0;
      case (state_r)
         ST_IDLE: begin
            cnt_s = 9'd0;
            if (tx_start) begin
               state_s = ST_STS;
               busy_s  = 1'b1;
            end else begin
               busy_s  = 1'b0;
            end
         end
         ST_STS: begin
            if (sample_req) begin
               valid_s   = 1'b1;
               rom_en_s  = 1'b1;
               rom_idx_s = {2'b00, cnt_r[3:0]};
               if (cnt_r == STS_LAST) begin
                  state_s = ST_LTS_GI;
                  cnt_s   = 9'd0;
               end else begin
                  cnt_s   = cnt_r + 9'd1;
               end
            end else begin
               cnt_s = cnt_r;
            end
         end
         ST_LTS_GI: begin
            if (sample_req) begin
               valid_s   = 1'b1;
               rom_en_s  = 1'b1;
               sel_lts_s = 1'b1;
               rom_idx_s = GI_BASE + cnt_r[5:0];
               if (cnt_r == GI_LAST) begin
                  state_s = ST_LTS;
                  cnt_s   = 9'd0;
               end else begin
                  cnt_s   = cnt_r + 9'd1;
               end
            end else begin
               cnt_s = cnt_r;
            end
         end
         ST_LTS: begin
            if (sample_req) begin
               valid_s   = 1'b1;
               rom_en_s  = 1'b1;
               sel_lts_s = 1'b1;
               rom_idx_s = cnt_r[5:0];
               if (cnt_r == LTS_LAST) begin
                  state_s = ST_PAYLOAD;
                  cnt_s   = 9'd0;
                  done_s  = 1'b1;
               end else begin
                  cnt_s   = cnt_r + 9'd1;
               end
            end else begin
               cnt_s = cnt_r;
            end
         end
         ST_PAYLOAD: begin
            cnt_s = 9'd0;
            if (sample_req) begin
               valid_s = 1'b1;
               if (payload_in_valid) begin
                  ready_s    = enable & ~rst;
                  ext_en_s   = 1'b1;
                  ext_data_s = {payload_in_q, payload_in_i};
                  if (payload_in_last) begin
                     state_s = ST_IDLE;
                     busy_s  = 1'b0;
                  end else begin
                     state_s = ST_PAYLOAD;
                  end
               end else begin
                  // Starved: emit 0+j0 so the DAC keeps its sample cadence.
                  underrun_s = 1'b1;
               end
            end else begin
               valid_s = 1'b0;
            end
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = 9'd0;
            busy_s  = 1'b0;
         end
      endcase
   end

   // Control register; reset or disable returns to IDLE with everything cleared.
   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         state_r    <= ST_IDLE;
         cnt_r      <= 9'd0;
         valid_r    <= 1'b0;
         done_r     <= 1'b0;
         underrun_r <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         cnt_r      <= cnt_s;
         valid_r    <= valid_s;
         done_r     <= done_s;
         underrun_r <= underrun_s;
         busy_r     <= busy_s;
      end
   end

   preamble_rom u_rom (
      .clk      (clk),
      .rst      (rst),
      .clr      (~enable),
      .rom_en   (rom_en_s),
      .sel_lts  (sel_lts_s),
      .idx      (rom_idx_s),
      .ext_en   (ext_en_s),
      .ext_data (ext_data_s),
      .dout     (out_word_s)
   );

   assign payload_in_ready = ready_s;
   assign sample_out_valid = valid_r;
   assign sample_out_i     = out_word_s[15:0];
   assign sample_out_q     = out_word_s[31:16];
   assign preamble_done    = done_r;
   assign tx_busy          = busy_r;
   assign underrun_err     = underrun_r;

endmodule

// File: tb/tb_lts_sts_preamble_gen.sv
// Scoreboard bench for lts_sts_preamble_gen: each accepted sample request
// pushes the expected sample, which is popped one cycle later at the output.
module tb_lts_sts_preamble_gen;

   logic        clk = 1'b0;
   logic        rst, enable, tx_start, sample_req;
   logic        payload_in_valid, payload_in_last;
   logic [15:0] payload_in_i, payload_in_q;
   logic        payload_in_ready, sample_out_valid, preamble_done, tx_busy, underrun_err;
   logic [15:0] sample_out_i, sample_out_q;

   always #5 clk = ~clk;

   lts_sts_preamble_gen dut (
      .clk(clk), .rst(rst), .enable(enable), .tx_start(tx_start),
      .sample_req(sample_req), .payload_in_valid(payload_in_valid),
      .payload_in_i(payload_in_i), .payload_in_q(payload_in_q),
      .payload_in_last(payload_in_last), .payload_in_ready(payload_in_ready),
      .sample_out_valid(sample_out_valid), .sample_out_i(sample_out_i),
      .sample_out_q(sample_out_q), .preamble_done(preamble_done),
      .tx_busy(tx_busy), .underrun_err(underrun_err)
   );

   typedef struct {
      logic [31:0] d;
      logic        done;
      logic        unr;
      int          p;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   pend     = 1'b0;
   bit   m_busy   = 1'b0;
   int   m_p      = 0;
   int   valid_cnt, done_cnt, unr_cnt, ready_cnt;

   // Reference tables from the standard sequences; LTS built from its
   // conjugate symmetry x[64-n] = conj(x[n]).
   int sts_i [16] = '{1507,-4325,-426,4686,3015,4686,-426,-4325,1507,66,-2589,-426,0,-426,-2589,66};
   int sts_q [16] = '{1507,66,-2589,-426,0,-426,-2589,66,1507,-4325,-426,4686,3015,4686,-426,-4325};
   int lts_hi [33] = '{5120,-164,1311,3178,688,1966,-3768,-1245,3211,1737,33,-4489,786,1933,-721,3899,
                       2032,1212,-1868,-4293,2687,2294,-1966,-1835,-1147,-3998,-4162,2458,-98,-3015,3015,393,-5120};
   int lts_hq [33] = '{0,-3932,-3637,2720,918,-2884,-1802,-3473,-852,131,-3768,-1540,-1933,-492,5276,-131,
                       -2032,3211,1278,2130,3015,459,2654,-721,-4948,-557,-688,-2425,1769,3768,3473,3211,0};
   int lts_i [64];
   int lts_q [64];

   function automatic logic [31:0] exp_pre(input int p);
      int k;
      if (p < 160) begin
         k = p % 16;
         return {16'(sts_q[k]), 16'(sts_i[k])};
      end else if (p < 192) begin
         k = 32 + (p - 160);
      end else begin
         k = (p - 192) % 64;
      end
      return {16'(lts_q[k]), 16'(lts_i[k])};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // One clock: check outputs answering the previous cycle, then drive this one.
   task automatic cycle(input bit req, input bit start, input bit pv,
                        input logic [15:0] pi, input logic [15:0] pq,
                        input bit plast, input bit r, input bit en);
      exp_t e;
      bit   exp_rdy;
      @(posedge clk);
      #1;
      if (pend) begin
         e = sb.pop_front();
         check_eq("valid", 32'(sample_out_valid), 32'd1);
         check_eq("data", {sample_out_q, sample_out_i}, e.d);
         check_eq("done", 32'(preamble_done), 32'(e.done));
         check_eq("underrun", 32'(underrun_err), 32'(e.unr));
         if (e.p == 0 || e.p == 16) check_eq("sts_anchor", {sample_out_q, sample_out_i}, 32'h05E3_05E3);
         if (e.p == 160) check_eq("gi_anchor", {sample_out_q, sample_out_i}, 32'h0000_EC00);
         if (e.p == 192) check_eq("lts_anchor", {sample_out_q, sample_out_i}, 32'h0000_1400);
      end else begin
         check_eq("idle_valid", 32'(sample_out_valid), 32'd0);
         check_eq("idle_data", {sample_out_q, sample_out_i}, 32'd0);
         check_eq("idle_done", 32'(preamble_done), 32'd0);
         check_eq("idle_underrun", 32'(underrun_err), 32'd0);
      end
      check_eq("busy", 32'(tx_busy), 32'(m_busy));
      if (sample_out_valid) valid_cnt++;
      if (preamble_done)    done_cnt++;
      if (underrun_err)     unr_cnt++;

      sample_req = req; tx_start = start; payload_in_valid = pv;
      payload_in_i = pi; payload_in_q = pq; payload_in_last = plast;
      rst = r; enable = en;
      #1;
      exp_rdy = m_busy && (m_p >= 320) && req && pv && en && !r;
      check_eq("ready", 32'(payload_in_ready), 32'(exp_rdy));
      if (payload_in_ready) ready_cnt++;

      pend = 1'b0;
      if (r || !en) begin
         m_busy = 1'b0;
         m_p    = 0;
      end else if (!m_busy) begin
         if (start) begin
            m_busy = 1'b1;
            m_p    = 0;
         end
      end else if (req) begin
         pend = 1'b1;
         e.done = 1'b0; e.unr = 1'b0; e.p = -1;
         if (m_p < 320) begin
            e.d = exp_pre(m_p); e.done = (m_p == 319); e.p = m_p;
            m_p++;
         end else if (pv) begin
            e.d = {pq, pi};
            if (plast) m_busy = 1'b0;
         end else begin
            e.d = 32'd0; e.unr = 1'b1;
         end
         sb.push_back(e);
      end
   endtask

   task automatic run_frame(input int period, input int npay, input int hole_at,
                            input int abort_at, input bit use_en, input bit dup_start);
      int  p_drv = 0;
      int  k = 0;
      int  holes = 0;
      int  c = 0;
      bit  req, pv, aborted;
      logic [15:0] kk;
      aborted = 1'b0;
      valid_cnt = 0; done_cnt = 0; unr_cnt = 0; ready_cnt = 0;
      // request in the start-acceptance cycle must be ignored
      cycle(1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
      while (p_drv < 320 && !aborted) begin
         req = ((c % period) == 0); c++;
         if (abort_at >= 0 && p_drv == abort_at && req) begin
            cycle(1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, !use_en, !use_en);
            aborted = 1'b1;
         end else begin
            cycle(req, dup_start && (p_drv == 20 || p_drv == 50), 1'b0,
                  16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
            if (req) p_drv++;
         end
      end
      while (!aborted && k < npay) begin
         req = ((c % period) == 0); c++;
         pv  = !(k == hole_at && holes < 3);
         if (req && !pv) holes++;
         kk = 16'(k);
         cycle(req, 1'b0, pv, kk, -kk, (k == npay - 1), 1'b0, 1'b1);
         if (req && pv) k++;
      end
      for (int t = 0; t < 4; t++)
         cycle(1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
      if (aborted) begin
         check_eq("abort_valids", 32'(valid_cnt), 32'(abort_at));
         check_eq("abort_done", 32'(done_cnt), 32'd0);
      end else begin
         check_eq("frame_valids", 32'(valid_cnt), 32'(320 + npay + holes));
         check_eq("frame_done", 32'(done_cnt), 32'd1);
         check_eq("frame_underruns", 32'(unr_cnt), 32'(hole_at >= 0 ? 3 : 0));
         check_eq("frame_ready", 32'(ready_cnt), 32'(npay));
      end
   endtask

   initial begin
      for (int n = 0; n < 33; n++) begin
         lts_i[n] = lts_hi[n];
         lts_q[n] = lts_hq[n];
      end
      for (int n = 1; n < 32; n++) begin
         lts_i[64 - n] = lts_hi[n];
         lts_q[64 - n] = -lts_hq[n];
      end
      rst = 1'b1; enable = 1'b1; tx_start = 1'b0; sample_req = 1'b0;
      payload_in_valid = 1'b0; payload_in_i = 16'd0; payload_in_q = 16'd0;
      payload_in_last = 1'b0;
      for (int t = 0; t < 3; t++)
         cycle(1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 1'b1);

      run_frame(1, 80, -1, -1, 1'b0, 1'b1);   // full-rate, 80-sample ramp, repeated starts
      run_frame(4, 12, 5, -1, 1'b0, 1'b0);    // every 4th cycle, 3 underruns mid-payload
      run_frame(1, 8, -1, 100, 1'b0, 1'b0);   // rst at sample 100
      run_frame(2, 8, -1, 100, 1'b1, 1'b0);   // enable low at sample 100
      run_frame(1, 8, -1, -1, 1'b0, 1'b0);    // clean restart after abort

      check_eq("sb_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
